// File: rtl/smartnic_250mhz_c2h_gate_pkg.sv
// Shared types and helpers for the C2H packet gate: tuser layout, gate state, keep popcount.
package smartnic_250mhz_c2h_gate_pkg;

    localparam int KEEP_MAX     = 64;
    localparam int BYTE_INC_WID = $clog2(KEEP_MAX + 1);

    typedef struct packed {
        logic [15:0] size;
        logic [15:0] src;
        logic [15:0] dst;
        logic        rss_hash_valid;
        logic [11:0] rss_hash;
    } tuser_c2h_t;

    typedef enum logic [1:0] {
        SOP,
        PASS,
        DROP
    } gate_state_t;

    function automatic logic [BYTE_INC_WID-1:0] popcount(input logic [KEEP_MAX-1:0] keep);
        logic [BYTE_INC_WID-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + BYTE_INC_WID'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/smartnic_250mhz_c2h_gate_if.sv
// AXI-Stream C2H bus bundle; master drives payload and valid, slave drives ready.
interface smartnic_250mhz_c2h_gate_if #(
    parameter int DATA_BYTE_WID = 64,
    parameter int TUSER_WID     = 61
);
    logic                       tvalid;
    logic                       tready;
    logic [8*DATA_BYTE_WID-1:0] tdata;
    logic [DATA_BYTE_WID-1:0]   tkeep;
    logic                       tlast;
    logic [TUSER_WID-1:0]       tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/smartnic_250mhz_c2h_gate_pkt_counter.sv
// Forwarded-packet, forwarded-byte and dropped-packet counters with wrap and clear-with-increment.
module axi4s_pkt_counter #(
    parameter int CNT_WID      = 32,
    parameter int BYTE_CNT_WID = 48,
    parameter int INC_WID      = 7
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    clr,
    input  logic                    inc_pkt,
    input  logic                    inc_drop,
    input  logic [INC_WID-1:0]      inc_bytes,
    output logic [CNT_WID-1:0]      pkt_cnt,
    output logic [BYTE_CNT_WID-1:0] byte_cnt,
    output logic [CNT_WID-1:0]      drop_cnt
);

    // A clear coinciding with an event restarts from that event rather than losing it.
    always_ff @(posedge clk) begin
        if (srst) begin
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            pkt_cnt  <= (clr ? '0 : pkt_cnt)  + CNT_WID'(inc_pkt);
            byte_cnt <= (clr ? '0 : byte_cnt) + BYTE_CNT_WID'(inc_bytes);
            drop_cnt <= (clr ? '0 : drop_cnt) + CNT_WID'(inc_drop);
        end
    end

endmodule

// File: rtl/smartnic_250mhz_c2h_gate.sv
// C2H packet gate: forwards or drops whole packets through one register stage and keeps statistics.
module smartnic_250mhz_c2h_gate
    import smartnic_250mhz_c2h_gate_pkg::*;
#(
    parameter int DATA_BYTE_WID = 64,
    parameter int TUSER_WID     = 61,
    parameter int CNT_WID       = 32,
    parameter int BYTE_CNT_WID  = 48
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic                              en,
    input  logic                              cnt_clr,
    smartnic_250mhz_c2h_gate_if.slave         s,
    smartnic_250mhz_c2h_gate_if.master        m,
    output logic [CNT_WID-1:0]                pkt_cnt,
    output logic [BYTE_CNT_WID-1:0]           byte_cnt,
    output logic [CNT_WID-1:0]                drop_cnt,
    output logic                              active
);

    gate_state_t             state;
    logic                    accept;
    logic                    fwd;
    logic                    inc_pkt;
    logic                    inc_drop;
    logic [BYTE_INC_WID-1:0] inc_bytes;

    // DROP sinks beats without touching the output register, so it never waits on m.tready.
    assign s.tready  = !srst && (state == DROP || !m.tvalid || m.tready);
    assign accept    = s.tvalid && s.tready;
    assign fwd       = accept && (state == PASS || (state == SOP && en));
    assign inc_pkt   = fwd && s.tlast;
    assign inc_drop  = accept && !fwd && s.tlast;
    assign inc_bytes = fwd ? popcount(KEEP_MAX'(s.tkeep)) : '0;

    // Output stage: one register, payload held while stalled.
    always_ff @(posedge clk) begin
        if (srst) begin
            m.tvalid <= 1'b0;
            m.tdata  <= '0;
            m.tkeep  <= '0;
            m.tlast  <= 1'b0;
            m.tuser  <= '0;
        end else if (fwd) begin
            m.tvalid <= 1'b1;
            m.tdata  <= s.tdata;
            m.tkeep  <= s.tkeep;
            m.tlast  <= s.tlast;
            m.tuser  <= s.tuser;
        end else if (m.tready) begin
            m.tvalid <= 1'b0;
        end
    end

    // en is only consulted on the first beat; the packet's fate is then locked in.
    always_ff @(posedge clk) begin
        if (srst) begin
            state  <= SOP;
            active <= 1'b0;
        end else if (accept) begin
            unique case (state)
                SOP: begin
                    if (!s.tlast) begin
                        state  <= en ? PASS : DROP;
                        active <= 1'b1;
                    end
                end
                PASS, DROP: begin
                    if (s.tlast) begin
                        state  <= SOP;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state  <= SOP;
                    active <= 1'b0;
                end
            endcase
        end
    end

    axi4s_pkt_counter #(
        .CNT_WID      (CNT_WID),
        .BYTE_CNT_WID (BYTE_CNT_WID),
        .INC_WID      (BYTE_INC_WID)
    ) u_cnt (
        .clk       (clk),
        .srst      (srst),
        .clr       (cnt_clr),
        .inc_pkt   (inc_pkt),
        .inc_drop  (inc_drop),
        .inc_bytes (inc_bytes),
        .pkt_cnt   (pkt_cnt),
        .byte_cnt  (byte_cnt),
        .drop_cnt  (drop_cnt)
    );

endmodule

// File: tb/tb_smartnic_250mhz_c2h_gate.sv
// Bench for the C2H packet gate: packet-level reference model with an output scoreboard.
module tb_smartnic_250mhz_c2h_gate;

    localparam int DBW = 64;
    localparam int TUW = 61;
    localparam int CW  = 32;
    localparam int BW  = 12;
    localparam int DW  = 8 * DBW;

    typedef struct {
        logic [DW-1:0]  data;
        logic [DBW-1:0] keep;
        logic           last;
        logic [TUW-1:0] user;
    } beat_t;

    logic          clk     = 1'b0;
    logic          srst    = 1'b1;
    logic          en      = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;
    logic [BW-1:0] byte_cnt;
    logic          active;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    int rdy_mode = 0;
    bit clr_rand = 1'b0;
    int cyc      = 0;

    beat_t         exp_q[$];
    int            mst      = 0;
    logic [CW-1:0] mdl_pkt  = '0;
    logic [CW-1:0] mdl_drop = '0;
    logic [BW-1:0] mdl_byte = '0;

    smartnic_250mhz_c2h_gate_if #(.DATA_BYTE_WID(DBW), .TUSER_WID(TUW)) s_if ();
    smartnic_250mhz_c2h_gate_if #(.DATA_BYTE_WID(DBW), .TUSER_WID(TUW)) m_if ();

    smartnic_250mhz_c2h_gate #(
        .DATA_BYTE_WID (DBW),
        .TUSER_WID     (TUW),
        .CNT_WID       (CW),
        .BYTE_CNT_WID  (BW)
    ) dut (
        .clk      (clk),
        .srst     (srst),
        .en       (en),
        .cnt_clr  (cnt_clr),
        .s        (s_if),
        .m        (m_if),
        .pkt_cnt  (pkt_cnt),
        .byte_cnt (byte_cnt),
        .drop_cnt (drop_cnt),
        .active   (active)
    );

    always #2 clk = ~clk;

    function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [TUW-1:0] rand_user();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[TUW-1:0];
    endfunction

    function automatic logic [DBW-1:0] rand_keep();
        logic [63:0] t;
        int          sel;
        sel = $urandom_range(0, 3);
        if (sel == 0)      t = '1;
        else if (sel == 1) t = '0;
        else if (sel == 2) t = {$urandom(), $urandom()};
        else               t = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(1, 63);
        return t[DBW-1:0];
    endfunction

    // Reference model: decides each packet's fate from en at its first beat.
    always @(negedge clk) begin
        if (chk_on) begin
            bit    ev, er, acc, fw, ip, id;
            int    nb;
            beat_t b;
            ev = (exp_q.size() != 0);
            chk("m_tvalid", DW'(m_if.tvalid), DW'(ev));
            if (ev && m_if.tvalid === 1'b1) begin
                chk("m_tdata", m_if.tdata, exp_q[0].data);
                chk("m_tkeep", DW'(m_if.tkeep), DW'(exp_q[0].keep));
                chk("m_tlast", DW'(m_if.tlast), DW'(exp_q[0].last));
                chk("m_tuser", DW'(m_if.tuser), DW'(exp_q[0].user));
            end
            chk("pkt_cnt", DW'(pkt_cnt), DW'(mdl_pkt));
            chk("drop_cnt", DW'(drop_cnt), DW'(mdl_drop));
            chk("byte_cnt", DW'(byte_cnt), DW'(mdl_byte));
            chk("active", DW'(active), DW'(mst != 0));
            er = !srst && (mst == 2 || !ev || m_if.tready);
            chk("s_tready", DW'(s_if.tready), DW'(er));
            if (srst) begin
                exp_q.delete();
                mst      = 0;
                mdl_pkt  = '0;
                mdl_drop = '0;
                mdl_byte = '0;
            end else begin
                if (ev && m_if.tready) void'(exp_q.pop_front());
                acc = s_if.tvalid && er;
                ip  = 1'b0;
                id  = 1'b0;
                nb  = 0;
                if (acc) begin
                    fw = (mst == 1) || (mst == 0 && en);
                    if (fw) begin
                        b.data = s_if.tdata;
                        b.keep = s_if.tkeep;
                        b.last = s_if.tlast;
                        b.user = s_if.tuser;
                        exp_q.push_back(b);
                        nb = $countones(s_if.tkeep);
                    end
                    if (s_if.tlast) begin
                        if (fw) ip = 1'b1;
                        else    id = 1'b1;
                        mst = 0;
                    end else if (mst == 0) begin
                        mst = en ? 1 : 2;
                    end
                end
                mdl_pkt  = (cnt_clr ? '0 : mdl_pkt)  + CW'(ip);
                mdl_drop = (cnt_clr ? '0 : mdl_drop) + CW'(id);
                mdl_byte = (cnt_clr ? '0 : mdl_byte) + BW'(nb);
            end
        end
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rdy_mode == 0)      m_if.tready = 1'b1;
            else if (rdy_mode == 1) m_if.tready = ($urandom_range(0, 3) != 0);
            else                    m_if.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (clr_rand) cnt_clr = ($urandom_range(0, 15) == 0);
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [DBW-1:0] k, input logic l,
                        input logic [TUW-1:0] u, input int gap);
        int n;
        bit done;
        repeat (gap) begin
            s_if.tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tuser  = u;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = (s_if.tready === 1'b1);
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                chk("accept_timeout", DW'(0), DW'(1));
                done = 1'b1;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
    endtask

    task automatic cnt_expect(input string nm, input int p, input int b, input int d);
        @(negedge clk);
        chk({nm, "_pkt"}, DW'(pkt_cnt), DW'(p));
        chk({nm, "_byte"}, DW'(byte_cnt), DW'(b));
        chk({nm, "_drop"}, DW'(drop_cnt), DW'(d));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DBW-1:0] ones;
        ones = '1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_tdata", m_if.tdata, '0);
        chk("rst_tkeep", DW'(m_if.tkeep), '0);
        chk("rst_tlast", DW'(m_if.tlast), '0);
        chk("rst_tuser", DW'(m_if.tuser), '0);
        chk("rst_active", DW'(active), '0);
        chk("rst_s_tready", DW'(s_if.tready), '0);
        @(posedge clk);
        #1;
        srst = 1'b0;

        // Three-beat forwarded packet.
        en = 1'b1;
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), 64'h0000_0000_0000_FFFF, 1'b1, rand_user(), 0);
        idle(3);
        cnt_expect("pass3", 1, 144, 0);

        // Two-beat dropped packet.
        do_reset();
        en = 1'b0;
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), ones, 1'b1, rand_user(), 0);
        idle(3);
        cnt_expect("drop2", 0, 0, 1);

        // en falls mid-packet: packet completes, next one is dropped.
        do_reset();
        en = 1'b1;
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        en = 1'b0;
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), ones, 1'b1, rand_user(), 0);
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), ones, 1'b1, rand_user(), 0);
        idle(3);
        cnt_expect("en_mid", 1, 256, 1);

        // Back-pressure pattern against a continuous stream.
        en = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) send(rand_data(), rand_keep(), (i == 7), rand_user(), 0);
        rdy_mode = 0;
        idle(4);

        // Clear coinciding with a 64-byte tlast beat.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 15; i++) send(rand_data(), ones, 1'b1, rand_user(), 0);
        send(rand_data(), 64'h0000_00FF_FFFF_FFFF, 1'b1, rand_user(), 0);
        idle(2);
        cnt_expect("pre_clr", 16, 1000, 0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = rand_data();
        s_if.tkeep  = ones;
        s_if.tlast  = 1'b1;
        s_if.tuser  = rand_user();
        cnt_clr     = 1'b1;
        @(negedge clk);
        chk("clr_s_tready", DW'(s_if.tready), DW'(1));
        @(posedge clk);
        #1;
        cnt_clr     = 1'b0;
        s_if.tvalid = 1'b0;
        cnt_expect("clr_inc", 1, 64, 0);

        // Byte counter wrap.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 63; i++) send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), 64'h0000_0000_FFFF_FFFF, 1'b0, rand_user(), 0);
        idle(2);
        chk("pre_wrap_active", DW'(active), DW'(1));
        cnt_expect("pre_wrap", 0, 4064, 0);
        send(rand_data(), ones, 1'b1, rand_user(), 0);
        idle(2);
        cnt_expect("wrap", 1, 32, 0);

        // Reset mid-packet; the tail becomes a new packet judged by en at its first beat.
        en = 1'b1;
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        srst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tvalid", DW'(m_if.tvalid), DW'(0));
        chk("mid_rst_active", DW'(active), DW'(0));
        @(posedge clk);
        #1;
        srst = 1'b0;
        en = 1'b0;
        send(rand_data(), ones, 1'b0, rand_user(), 0);
        send(rand_data(), ones, 1'b1, rand_user(), 0);
        idle(2);
        cnt_expect("post_rst", 0, 0, 1);

        // Randomized traffic with random back-pressure, en toggling and clears.
        do_reset();
        rdy_mode = 1;
        clr_rand = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                en = $urandom_range(0, 1);
                send(rand_data(), rand_keep(), (i == len - 1), rand_user(), $urandom_range(0, 2));
            end
        end
        clr_rand = 1'b0;
        cnt_clr  = 1'b0;
        rdy_mode = 0;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
